// File: rtl/rom_dl_pkg.sv
// Shared types for the ROM download path: region map of the EPROM/PROM image,
// controller states and the address-to-region decode function.
package rom_dl_pkg;

   typedef enum logic [4:0] {
      REG_EP0   = 5'd0,
      REG_EP0B  = 5'd1,
      REG_EP1   = 5'd2,
      REG_EP2   = 5'd3,
      REG_EP3   = 5'd4,
      REG_EP4   = 5'd5,
      REG_DUMMY = 5'd6,
      REG_EP5   = 5'd7,
      REG_EP6   = 5'd8,
      REG_EP7   = 5'd9,
      REG_EP8   = 5'd10,
      REG_EP9   = 5'd11,
      REG_EP10  = 5'd12,
      REG_EP11  = 5'd13,
      REG_EP12  = 5'd14,
      REG_CP1   = 5'd15,
      REG_CP2   = 5'd16,
      REG_CP3   = 5'd17,
      REG_EP13  = 5'd18
   } region_t;

   // Exclusive upper address of each region, ascending.
   localparam logic [31:0] END_EP0   = 32'h0000_4000;
   localparam logic [31:0] END_EP0B  = 32'h0000_8000;
   localparam logic [31:0] END_EP1   = 32'h0001_0000;
   localparam logic [31:0] END_EP2   = 32'h0001_2000;
   localparam logic [31:0] END_EP3   = 32'h0001_4000;
   localparam logic [31:0] END_EP4   = 32'h0001_6000;
   localparam logic [31:0] END_DUMMY = 32'h0001_8000;
   localparam logic [31:0] END_EP5   = 32'h0002_0000;
   localparam logic [31:0] END_EP6   = 32'h0002_8000;
   localparam logic [31:0] END_EP7   = 32'h0003_0000;
   localparam logic [31:0] END_EP8   = 32'h0003_8000;
   localparam logic [31:0] END_EP9   = 32'h0004_0000;
   localparam logic [31:0] END_EP10  = 32'h0004_8000;
   localparam logic [31:0] END_EP11  = 32'h0005_0000;
   localparam logic [31:0] END_EP12  = 32'h0005_8000;
   localparam logic [31:0] END_CP1   = 32'h0005_8100;
   localparam logic [31:0] END_CP2   = 32'h0005_8200;
   localparam logic [31:0] END_CP3   = 32'h0005_8300;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LOAD   = 2'd1,
      SETTLE = 2'd2,
      READY  = 2'd3
   } dl_state_t;

   // Anything past the last PROM lands in ep13 so stray bytes still go somewhere.
   function automatic region_t region_of(input logic [31:0] addr);
      region_t r;
      if      (addr < END_EP0)   r = REG_EP0;
      else if (addr < END_EP0B)  r = REG_EP0B;
      else if (addr < END_EP1)   r = REG_EP1;
      else if (addr < END_EP2)   r = REG_EP2;
      else if (addr < END_EP3)   r = REG_EP3;
      else if (addr < END_EP4)   r = REG_EP4;
      else if (addr < END_DUMMY) r = REG_DUMMY;
      else if (addr < END_EP5)   r = REG_EP5;
      else if (addr < END_EP6)   r = REG_EP6;
      else if (addr < END_EP7)   r = REG_EP7;
      else if (addr < END_EP8)   r = REG_EP8;
      else if (addr < END_EP9)   r = REG_EP9;
      else if (addr < END_EP10)  r = REG_EP10;
      else if (addr < END_EP11)  r = REG_EP11;
      else if (addr < END_EP12)  r = REG_EP12;
      else if (addr < END_CP1)   r = REG_CP1;
      else if (addr < END_CP2)   r = REG_CP2;
      else if (addr < END_CP3)   r = REG_CP3;
      else                       r = REG_EP13;
      return r;
   endfunction

endpackage

// File: rtl/rom_region_decode.sv
// Combinational byte-address to ROM region index; chip selects are built from
// the registered index downstream. Addresses wider than 32 bits are not decoded.
module rom_region_decode
   import rom_dl_pkg::*;
#(
   parameter int ADDR_W = 25
) (
   input  logic [ADDR_W-1:0] addr,
   output logic [4:0]        region
);

   assign region = region_of(32'(addr));

endmodule

// File: rtl/rom_download_ctrl.sv
// Forwards the HPS ioctl ROM stream to the ROM RAMs with one cycle of latency,
// holds the core in reset while loading and settling, and checks image length.
module rom_download_ctrl
   import rom_dl_pkg::*;
#(
   parameter int          ADDR_W        = 25,
   parameter int unsigned EXPECTED_LEN  = 'h58300,
   parameter int          SETTLE_CYCLES = 16,
   parameter logic [7:0]  ROM_INDEX     = 8'd0
) (
   input  logic              CLK,
   input  logic              RESET_N,
   input  logic              IOCTL_DOWNLOAD,
   input  logic [7:0]        IOCTL_INDEX,
   input  logic              IOCTL_WR,
   input  logic [ADDR_W-1:0] IOCTL_ADDR,
   input  logic [7:0]        IOCTL_DOUT,
   output logic              DL_WR,
   output logic [ADDR_W-1:0] DL_ADDR,
   output logic [7:0]        DL_DATA,
   output logic [4:0]        DL_REGION,
   output logic              CORE_RESET,
   output logic              ROM_READY,
   output logic              LEN_ERR,
   output logic [ADDR_W-1:0] BYTE_COUNT
);

   localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

   dl_state_t         state, state_next;
   logic              dl_active, dl_active_q;
   logic              dl_rise, dl_fall;
   logic              wr_accept;
   logic              settle_done;
   logic [CNT_W-1:0]  settle_cnt;
   logic [4:0]        addr_region;
   logic [ADDR_W:0]   addr_inc;
   logic [ADDR_W-1:0] addr_end;

   rom_region_decode #(.ADDR_W(ADDR_W)) u_region (
      .addr   (IOCTL_ADDR),
      .region (addr_region)
   );

   // dl_active_q resets low, so a download already high at reset release is a rise.
   assign dl_active   = IOCTL_DOWNLOAD & (IOCTL_INDEX == ROM_INDEX);
   assign dl_rise     = dl_active & ~dl_active_q;
   assign dl_fall     = ~dl_active & dl_active_q;
   assign settle_done = (settle_cnt == '0);

   // Top address + 1 saturates instead of wrapping to zero.
   assign addr_inc = {1'b0, IOCTL_ADDR} + {{ADDR_W{1'b0}}, 1'b1};
   assign addr_end = addr_inc[ADDR_W] ? {ADDR_W{1'b1}} : addr_inc[ADDR_W-1:0];

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) state <= IDLE;
      else          state <= state_next;
   end

   always_comb begin
      state_next = state;
      CORE_RESET = 1'b1;
      ROM_READY  = 1'b0;
      wr_accept  = 1'b0;
      case (state)
         IDLE: begin
            if (dl_rise) state_next = LOAD;
         end
         LOAD: begin
            // The strobe on the falling-edge cycle is still forwarded.
            wr_accept = IOCTL_WR;
            if (dl_fall) state_next = SETTLE;
         end
         SETTLE: begin
            // A fresh download during settling restarts loading rather than being lost.
            if (dl_rise)          state_next = LOAD;
            else if (settle_done) state_next = READY;
         end
         READY: begin
            CORE_RESET = 1'b0;
            ROM_READY  = 1'b1;
            if (dl_rise) state_next = LOAD;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         dl_active_q <= 1'b0;
         DL_WR       <= 1'b0;
         DL_ADDR     <= '0;
         DL_DATA     <= '0;
         DL_REGION   <= '0;
         LEN_ERR     <= 1'b0;
         BYTE_COUNT  <= '0;
         settle_cnt  <= '0;
      end else begin
         dl_active_q <= dl_active;
         DL_WR       <= wr_accept;
         if (wr_accept) begin
            DL_ADDR   <= IOCTL_ADDR;
            DL_DATA   <= IOCTL_DOUT;
            DL_REGION <= addr_region;
         end

         if (state_next == LOAD && state != LOAD) begin
            BYTE_COUNT <= '0;
            LEN_ERR    <= 1'b0;
         end else if (wr_accept && (addr_end > BYTE_COUNT)) begin
            BYTE_COUNT <= addr_end;
         end

         if (state == LOAD && dl_fall)
            settle_cnt <= CNT_W'(SETTLE_CYCLES - 1);
         else if (state == SETTLE && !settle_done)
            settle_cnt <= settle_cnt - CNT_W'(1);

         if (state == SETTLE && state_next == READY)
            LEN_ERR <= (BYTE_COUNT != ADDR_W'(EXPECTED_LEN));
      end
   end

endmodule

// File: doc/rom_download_ctrl.md
Name: rom_download_ctrl

Overview:
- Sequences the HPS ioctl ROM download into the per-EPROM/PROM dual-port RAMs.
- Registers the ioctl stream and decodes each byte to a region index (one-hot chip selects are derived from it downstream).
- Holds the game core in reset during download and a settle period afterwards, then releases it.
- Reports a length error when the received image size does not match the expected ROM set size.

Parameters:
- ADDR_W, 25: width of ioctl and download address.
- EXPECTED_LEN, 'h58300: required image length in bytes (last PROM ends at 'h582FF).
- SETTLE_CYCLES, 16: cycles to keep CORE_RESET asserted after download ends; minimum 1.
- ROM_INDEX, 8'd0: ioctl index that carries the ROM image.

Ports:
- CLK  in  1  system/download clock.
- RESET_N  in  1  asynchronous active-low reset.
- IOCTL_DOWNLOAD  in  1  high while the HPS transfer is active.
- IOCTL_INDEX  in  8  transfer index.
- IOCTL_WR  in  1  one-cycle byte strobe.
- IOCTL_ADDR  in  ADDR_W  byte address.
- IOCTL_DOUT  in  8  byte data.
- DL_WR  out  1  registered write strobe to the ROM RAMs.
- DL_ADDR  out  ADDR_W  registered address.
- DL_DATA  out  8  registered data.
- DL_REGION  out  5  region index of DL_ADDR (see package).
- CORE_RESET  out  1  active-high reset to the CPUs and video.
- ROM_READY  out  1  image loaded and settled.
- LEN_ERR  out  1  sticky length mismatch for the last download.
- BYTE_COUNT  out  ADDR_W  highest written address + 1.

Behaviour:
- Reset values: DL_WR=0, DL_ADDR=0, DL_DATA=0, DL_REGION=0, CORE_RESET=1, ROM_READY=0, LEN_ERR=0, BYTE_COUNT=0, state=IDLE.
- dl_active = IOCTL_DOWNLOAD & (IOCTL_INDEX==ROM_INDEX). Downloads with any other index are ignored entirely: no strobes, no state change.
- State IDLE:
  - CORE_RESET=1, ROM_READY=0.
  - Rising edge of dl_active -> LOAD; clear BYTE_COUNT and LEN_ERR.
- State LOAD:
  - Each cycle with IOCTL_WR=1 produces DL_WR=1 exactly one cycle later.
  - DL_ADDR, DL_DATA and DL_REGION are captured in that same cycle, giving latency 1.
  - Back-to-back strobes are passed through with no gaps.
  - BYTE_COUNT <= max(BYTE_COUNT, IOCTL_ADDR+1).
  - Falling edge of dl_active -> SETTLE and load the settle counter with SETTLE_CYCLES-1. A strobe coinciding with the falling edge is still forwarded.
- State SETTLE:
  - CORE_RESET=1; the counter decrements each cycle.
  - At 0 -> READY. LEN_ERR <= (BYTE_COUNT != EXPECTED_LEN), registered on the SETTLE->READY transition.
- State READY:
  - CORE_RESET=0, ROM_READY=1.
  - A new rising edge of dl_active -> LOAD. In the same cycle, CORE_RESET rises and ROM_READY falls.
  - LEN_ERR and BYTE_COUNT clear on entry to LOAD.
- IOCTL_WR outside LOAD is ignored; DL_WR stays 0.
- Region decode (regions by ascending address boundary):
  - 0 ep0 <'h04000; 1 ep0b <'h08000; 2 ep1 <'h10000; 3 ep2 <'h12000; 4 ep3 <'h14000; 5 ep4 <'h16000; 6 dummy <'h18000.
  - 7 ep5 <'h20000; 8 ep6 <'h28000; 9 ep7 <'h30000; 10 ep8 <'h38000.
  - 11 ep9 <'h40000; 12 ep10 <'h48000; 13 ep11 <'h50000; 14 ep12 <'h58000.
  - 15 cp1 <'h58100; 16 cp2 <'h58200; 17 cp3 <'h58300; 18 ep13 otherwise.
  - Addresses at or beyond 'h58300 still write, to region 18.
- Reset mid-download: all outputs return to reset values immediately. A still-high dl_active after reset release counts as a rising edge on the first clock, so the controller enters LOAD.
- Wrap: BYTE_COUNT saturates at 2^ADDR_W-1.

Decomposition:
- Package rom_dl_pkg holds:
  - the region enum (REG_EP0 .. REG_EP13, 5 bits);
  - the boundary address constants;
  - the state enum {IDLE, LOAD, SETTLE, READY};
  - the function region_of(addr).
- Sub-module rom_region_decode: combinational addr -> region, reusing region_of. The selector replacement uses it, and the one-hot CS outputs are derived from DL_REGION.

Test Plan:
- Reset release with dl_active=0 -> CORE_RESET=1, ROM_READY=0 held indefinitely, DL_WR never asserts.
- Full download of 'h58300 bytes, index 0, one strobe every 4 cycles:
  - each DL_WR is one cycle after IOCTL_WR, with matching addr/data;
  - DL_REGION changes at 'h04000 (0->1), 'h18000 (6->7), 'h58000 (14->15);
  - ROM_READY=1 and CORE_RESET=0 exactly SETTLE_CYCLES cycles after the download falls;
  - LEN_ERR=0.
- Short download ending at 'h57FFF -> BYTE_COUNT='h58000 and LEN_ERR=1 at READY.
- Index 1 download while in READY -> no DL_WR, ROM_READY stays 1.
- Back-to-back strobes with the final strobe on the falling edge of IOCTL_DOWNLOAD -> all bytes forwarded, including the last.
- RESET_N pulsed low mid-LOAD -> outputs return to reset values asynchronously, and the controller re-enters LOAD while the download is held high.
